// File: rtl/fir_arb_pkg.sv
// Shared types, defaults and the round-robin pick helper for the FIR TCDM arbiter.
package fir_arb_pkg;

  localparam int NR_DEFAULT              = 4;
  localparam int MAX_OUTSTANDING_DEFAULT = 4;
  localparam int NR_MAX                  = 16;

  typedef logic [$clog2(NR_DEFAULT)-1:0] rid_t;

  typedef struct packed {
    logic       vld;
    logic [3:0] idx;
  } rr_pick_t;

  // First set bit of req at or above ptr, wrapping modulo nr.
  function automatic rr_pick_t rr_first_one(input logic [NR_MAX-1:0] req,
                                            input logic [3:0]        ptr,
                                            input int unsigned       nr);
    rr_pick_t    pick;
    int unsigned k;
    pick = '0;
    for (int unsigned i = 0; i < NR_MAX; i++) begin
      k = (32'(ptr) + i) % nr;
      if (i < nr && !pick.vld && req[k[3:0]]) begin
        pick.vld = 1'b1;
        pick.idx = k[3:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fir_tcdm_rr_arbiter_if.sv
// Requester-side and memory-side TCDM signals of the arbiter; slave is the arbiter's view.
interface fir_tcdm_rr_arbiter_if #(
  parameter int NR = fir_arb_pkg::NR_DEFAULT,
  parameter int AW = 32,
  parameter int DW = 32
);

  logic [NR-1:0]             req_i;
  logic [NR-1:0][AW-1:0]     add_i;
  logic [NR-1:0]             wen_i;
  logic [NR-1:0][DW/8-1:0]   be_i;
  logic [NR-1:0][DW-1:0]     data_i;
  logic [NR-1:0]             gnt_o;
  logic [DW-1:0]             r_data_o;
  logic [NR-1:0]             r_valid_o;

  logic                      tcdm_req_o;
  logic [AW-1:0]             tcdm_add_o;
  logic                      tcdm_wen_o;
  logic [DW/8-1:0]           tcdm_be_o;
  logic [DW-1:0]             tcdm_data_o;
  logic                      tcdm_gnt_i;
  logic [DW-1:0]             tcdm_r_data_i;
  logic                      tcdm_r_valid_i;

  modport slave (
    input  req_i, add_i, wen_i, be_i, data_i,
    input  tcdm_gnt_i, tcdm_r_data_i, tcdm_r_valid_i,
    output gnt_o, r_data_o, r_valid_o,
    output tcdm_req_o, tcdm_add_o, tcdm_wen_o, tcdm_be_o, tcdm_data_o
  );

  modport master (
    output req_i, add_i, wen_i, be_i, data_i,
    output tcdm_gnt_i, tcdm_r_data_i, tcdm_r_valid_i,
    input  gnt_o, r_data_o, r_valid_o,
    input  tcdm_req_o, tcdm_add_o, tcdm_wen_o, tcdm_be_o, tcdm_data_o
  );

endinterface

// File: rtl/fir_tcdm_id_fifo.sv
// In-order requester-ID FIFO: one-cycle write-to-read, push ignored when full, pop ignored when empty.
module fir_tcdm_id_fifo #(
  parameter  int W     = 2,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_d  = do_push ? ptr_inc(wr_q) : wr_q;
    rd_d  = do_pop  ? ptr_inc(rd_q) : rd_q;
    cnt_d = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
    if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: only entries counted by cnt_q are ever read as valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/fir_tcdm_rr_arbiter.sv
// Round-robin share of one TCDM port: zero-latency request/grant path, responses routed in order
// through an ID FIFO; when MAX_OUTSTANDING transactions are in flight, requests are held off.
module fir_tcdm_rr_arbiter
  import fir_arb_pkg::*;
#(
  parameter  int NR              = NR_DEFAULT,
  parameter  int MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT,
  parameter  int AW              = 32,
  parameter  int DW              = 32,
  localparam int CW              = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  fir_tcdm_rr_arbiter_if.slave  bus,
  output logic [CW-1:0]         outstanding_o,
  output logic                  err_o
);

  localparam int IDW = $clog2(NR);
  typedef logic [IDW-1:0] id_t;

  id_t             ptr_q, ptr_d;
  id_t             winner, sel, head_id;
  logic            err_q, err_d;
  rr_pick_t        pick;
  logic            fifo_full, fifo_empty;
  logic            fwd, hs, pop;
  logic [AW-1:0]   add_sel;
  logic [DW-1:0]   data_sel;
  logic [DW/8-1:0] be_sel;
  logic            wen_sel;

  always_comb begin
    pick   = rr_first_one(NR_MAX'(bus.req_i), 4'(ptr_q), NR);
    winner = id_t'(pick.idx);
    // Full is judged on registered occupancy only, so a same-cycle pop never enables a request.
    fwd    = pick.vld & ~fifo_full;
    hs     = fwd & bus.tcdm_gnt_i;
    sel    = fwd ? winner : '0;
  end

  assign add_sel  = bus.add_i[sel];
  assign wen_sel  = bus.wen_i[sel];
  assign be_sel   = bus.be_i[sel];
  assign data_sel = bus.data_i[sel];

  assign bus.tcdm_req_o  = fwd;
  assign bus.tcdm_add_o  = add_sel;
  assign bus.tcdm_wen_o  = wen_sel;
  assign bus.tcdm_be_o   = be_sel;
  assign bus.tcdm_data_o = data_sel;
  assign bus.r_data_o    = bus.tcdm_r_data_i;

  assign pop = bus.tcdm_r_valid_i & ~fifo_empty;

  always_comb begin
    bus.gnt_o     = '0;
    bus.r_valid_o = '0;
    for (int k = 0; k < NR; k++) begin
      bus.gnt_o[k]     = hs && (winner == id_t'(k));
      bus.r_valid_o[k] = pop && (head_id == id_t'(k));
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (hs) ptr_d = (32'(winner) == NR - 1) ? '0 : winner + 1'b1;
    // A response with nothing in flight cannot be routed; flag it until reset/clear.
    err_d = err_q | (bus.tcdm_r_valid_i & fifo_empty);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      err_q <= 1'b0;
    end else if (clear_i) begin
      ptr_q <= '0;
      err_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

  fir_tcdm_id_fifo #(
    .W     (IDW),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .push_i  (hs),
    .pop_i   (pop),
    .data_i  (winner),
    .data_o  (head_id),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outstanding_o)
  );

endmodule

// File: tb/tb_fir_tcdm_rr_arbiter.sv
// Directed and random bench for the TCDM round-robin arbiter against a queue-based reference model.
`timescale 1ns/1ps
module tb_fir_tcdm_rr_arbiter;
  import fir_arb_pkg::*;

  localparam int NR = 4;
  localparam int MO = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic [2:0] outstanding;
  logic       err;

  always #5 clk = ~clk;

  fir_tcdm_rr_arbiter_if #(.NR(NR), .AW(AW), .DW(DW)) bus ();

  fir_tcdm_rr_arbiter #(.NR(NR), .MAX_OUTSTANDING(MO), .AW(AW), .DW(DW)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .clear_i       (clear),
    .bus           (bus),
    .outstanding_o (outstanding),
    .err_o         (err)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: pointer, queue of in-flight requester IDs, sticky error.
  int ptr;
  int q[$];
  bit m_err;
  int cyc;
  // Memory model: in-order response schedule.
  int          mem_due[$];
  logic [31:0] mem_dat[$];
  bit mem_hold, spurious, rnd_mode;
  int lat;
  // Logs of what the DUT actually did.
  int          glog[$], gcy[$], rvlog[$], rvcy[$];
  logic [31:0] rdlog[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int qat(input int qq[$], input int i);
    return (i < qq.size()) ? qq[i] : -1;
  endfunction

  function automatic logic [31:0] dat_at(input int i);
    return (i < rdlog.size()) ? rdlog[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic new_fields(input int k);
    bus.add_i[k]  = $urandom;
    bus.wen_i[k]  = 1'($urandom);
    bus.be_i[k]   = 4'($urandom);
    bus.data_i[k] = $urandom;
  endtask

  task automatic clear_logs();
    glog.delete(); gcy.delete(); rvlog.delete(); rvcy.delete(); rdlog.delete();
  endtask

  // One clock cycle: memory drives, model predicts, DUT checked, model advances.
  task automatic step();
    bit real_rsp, rv, found, fwd, hs, pop;
    int w, sel;
    logic [NR-1:0] eg, erv;
    real_rsp = !spurious && !mem_hold && mem_due.size() > 0 && mem_due[0] <= cyc;
    rv = spurious || real_rsp;
    bus.tcdm_r_valid_i = rv;
    bus.tcdm_r_data_i  = real_rsp ? mem_dat[0] : $urandom;
    #1;
    found = 0; w = 0;
    for (int i = 0; i < NR; i++) begin
      int k;
      k = (ptr + i) % NR;
      if (!found && bus.req_i[k]) begin found = 1; w = k; end
    end
    fwd = found && (q.size() < MO);
    hs  = fwd && bus.tcdm_gnt_i;
    pop = rv && (q.size() > 0);
    sel = fwd ? w : 0;
    eg = '0; erv = '0;
    if (hs)  eg[w] = 1'b1;
    if (pop) erv[q[0]] = 1'b1;
    chk("tcdm_req",    32'(bus.tcdm_req_o),  32'(fwd));
    chk("tcdm_add",    bus.tcdm_add_o,       bus.add_i[sel]);
    chk("tcdm_wen",    32'(bus.tcdm_wen_o),  32'(bus.wen_i[sel]));
    chk("tcdm_be",     32'(bus.tcdm_be_o),   32'(bus.be_i[sel]));
    chk("tcdm_data",   bus.tcdm_data_o,      bus.data_i[sel]);
    chk("gnt",         32'(bus.gnt_o),       32'(eg));
    chk("r_valid",     32'(bus.r_valid_o),   32'(erv));
    chk("r_data",      bus.r_data_o,         bus.tcdm_r_data_i);
    chk("outstanding", 32'(outstanding),     32'(q.size()));
    chk("err",         32'(err),             32'(m_err));
    for (int k = 0; k < NR; k++) begin
      if (bus.gnt_o[k]) begin glog.push_back(k); gcy.push_back(cyc); end
      if (bus.r_valid_o[k]) begin rvlog.push_back(k); rvcy.push_back(cyc); rdlog.push_back(bus.r_data_o); end
    end
    @(posedge clk);
    #1;
    if (hs) begin
      mem_due.push_back(cyc + lat);
      mem_dat.push_back(32'hA5A5_0000 | 32'(w));
    end
    if (real_rsp) begin
      void'(mem_due.pop_front());
      void'(mem_dat.pop_front());
    end
    if (rst || clear) begin
      q.delete(); ptr = 0; m_err = 0;
    end else begin
      if (rv && q.size() == 0) m_err = 1;
      if (pop) void'(q.pop_front());
      if (hs) begin q.push_back(w); ptr = (w + 1) % NR; end
    end
    if (hs) new_fields(w);
    if (rnd_mode) begin
      for (int k = 0; k < NR; k++) begin
        if (!bus.req_i[k] || (hs && w == k)) begin
          bus.req_i[k] = 1'($urandom_range(0, 1));
          new_fields(k);
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    bus.req_i = '0; mem_hold = 0; spurious = 0; rnd_mode = 0;
    for (int i = 0; i < 60 && (q.size() > 0 || mem_due.size() > 0); i++) step();
    chk("drain_occ", 32'(outstanding), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, nfull;
    int fair_id[5];
    int prio_id[3];
    int ooo_id[3];
    fair_id = '{0, 1, 2, 3, 0};
    prio_id = '{3, 0, 1};
    ooo_id  = '{2, 0, 3};

    rst = 1'b1; clear = 1'b0;
    bus.req_i = '0; bus.add_i = '0; bus.wen_i = '0; bus.be_i = '0; bus.data_i = '0;
    bus.tcdm_gnt_i = 1'b0; bus.tcdm_r_valid_i = 1'b0; bus.tcdm_r_data_i = '0;
    ptr = 0; m_err = 0; cyc = 0; lat = 1; mem_hold = 0; spurious = 0; rnd_mode = 0;
    repeat (2) @(negedge clk);
    chk("rst_occ", 32'(outstanding),    32'd0);
    chk("rst_err", 32'(err),            32'd0);
    chk("rst_req", 32'(bus.tcdm_req_o), 32'd0);
    chk("rst_gnt", 32'(bus.gnt_o),      32'd0);
    chk("rst_rv",  32'(bus.r_valid_o),  32'd0);
    chk("rst_add", bus.tcdm_add_o,      32'd0);
    rst = 1'b0;
    for (int k = 0; k < NR; k++) new_fields(k);

    // Fairness with single-cycle memory.
    clear_logs(); bus.req_i = '1; bus.tcdm_gnt_i = 1'b1; lat = 1;
    repeat (5) step();
    drain();
    chk("fair_n", 32'(glog.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk("fair_id",  32'(qat(glog, i)), 32'(fair_id[i]));
      chk("fair_rv",  32'(qat(rvlog, i)), 32'(fair_id[i]));
      chk("fair_lat", 32'(qat(rvcy, i) - qat(gcy, i)), 32'd1);
    end

    // Pointer priority: move pointer to 2, then req 1011.
    bus.req_i = 4'b0010; step();
    clear_logs(); bus.req_i = 4'b1011;
    repeat (3) step();
    drain();
    for (int i = 0; i < 3; i++) chk("prio_id", 32'(qat(glog, i)), 32'(prio_id[i]));

    // Grant stall on requester 1.
    clear_logs(); bus.req_i = 4'b0010; bus.tcdm_gnt_i = 1'b0; c0 = cyc;
    repeat (5) step();
    bus.tcdm_gnt_i = 1'b1; step();
    drain();
    chk("stall_n",   32'(glog.size()), 32'd1);
    chk("stall_id",  32'(qat(glog, 0)), 32'd1);
    chk("stall_cyc", 32'(qat(gcy, 0)), 32'(c0 + 5));

    // Full FIFO with responses withheld.
    clear_logs(); lat = 1; mem_hold = 1; bus.req_i = '1; bus.tcdm_gnt_i = 1'b1;
    repeat (6) step();
    chk("full_occ", 32'(outstanding),    32'd4);
    chk("full_req", 32'(bus.tcdm_req_o), 32'd0);
    chk("full_n",   32'(glog.size()),    32'd4);
    nfull = glog.size();
    mem_hold = 0;
    step();
    chk("full_pop_nogrant", 32'(glog.size()), 32'(nfull));
    step();
    chk("full_regrant", 32'(glog.size()), 32'(nfull + 1));
    drain();

    // Out-of-order issue, in-order return, 3-cycle memory.
    clear_logs(); lat = 3;
    bus.req_i = 4'b0100; step();
    bus.req_i = 4'b0001; step();
    bus.req_i = 4'b1000; step();
    drain();
    for (int i = 0; i < 3; i++) begin
      chk("ooo_rv",   32'(qat(rvlog, i)), 32'(ooo_id[i]));
      chk("ooo_data", dat_at(i), 32'hA5A5_0000 | 32'(ooo_id[i]));
      chk("ooo_lat",  32'(qat(rvcy, i) - qat(gcy, i)), 32'd3);
    end

    // Random traffic.
    rnd_mode = 1;
    for (int k = 0; k < NR; k++) bus.req_i[k] = 1'($urandom_range(0, 1));
    for (int i = 0; i < 300; i++) begin
      bus.tcdm_gnt_i = ($urandom_range(0, 3) != 0);
      lat      = $urandom_range(1, 4);
      mem_hold = ($urandom_range(0, 7) == 0);
      step();
    end
    drain();

    // Spurious response, sticky error, soft clear.
    spurious = 1; step(); spurious = 0;
    repeat (3) step();
    chk("err_sticky", 32'(err), 32'd1);
    clear = 1'b1; step(); clear = 1'b0;
    chk("clr_err", 32'(err), 32'd0);
    spurious = 1; step(); spurious = 0;
    chk("err_again", 32'(err), 32'd1);

    // Asynchronous reset mid-burst.
    lat = 3; bus.req_i = '1; bus.tcdm_gnt_i = 1'b1;
    repeat (2) step();
    #2 rst = 1'b1;
    #1;
    chk("arst_occ", 32'(outstanding), 32'd0);
    chk("arst_err", 32'(err),         32'd0);
    q.delete(); ptr = 0; m_err = 0;
    step();
    rst = 1'b0;
    clear_logs();
    step();
    chk("arst_ptr", 32'(qat(glog, 0)), 32'd0);
    drain();
    chk("late_err", 32'(err), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fir_tcdm_rr_arbiter.md
Name: fir_tcdm_rr_arbiter

Overview:
- Shares one TCDM memory port between NR requesters, e.g. the HWPE streamer ports and the core data port, with round-robin fairness.
- Forwards requests combinationally.
- Tracks outstanding transactions in an in-order ID FIFO so each single-cycle r_valid response is routed back to the requester that issued it.
- Sits between the FIR accelerator/core masters and a memory bank port; replaces ad-hoc combinational response muxing.

Parameters:
- NR, 4, number of requesters (2..16).
- MAX_OUTSTANDING, 4, depth of the response-ID FIFO (power of 2, >=1).
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- clear_i  in  1  synchronous soft clear; same effect as reset.
- req_i  in  NR  per-requester request.
- add_i  in  NR x AW  per-requester address.
- wen_i  in  NR  per-requester write-enable, active-low (1 = read).
- be_i  in  NR x DW/8  per-requester byte enables.
- data_i  in  NR x DW  per-requester write data.
- gnt_o  out  NR  per-requester grant.
- r_data_o  out  DW  response data, broadcast to all requesters.
- r_valid_o  out  NR  per-requester response valid.
- tcdm_req_o  out  1  memory-side request.
- tcdm_add_o  out  AW  memory-side address.
- tcdm_wen_o  out  1  memory-side write-enable, active-low.
- tcdm_be_o  out  DW/8  memory-side byte enables.
- tcdm_data_o  out  DW  memory-side write data.
- tcdm_gnt_i  in  1  memory-side grant.
- tcdm_r_data_i  in  DW  memory-side response data.
- tcdm_r_valid_i  in  1  memory-side response valid.
- outstanding_o  out  clog2(MAX_OUTSTANDING)+1  current FIFO occupancy.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset/clear values:
  - rr pointer = 0; FIFO empty; outstanding_o = 0; err_o = 0.
  - All outputs that depend on requests are 0 while no req_i is set.
- Winner selection (combinational):
  - The winner is the first k with req_i[k]=1, scanning from the rr pointer upward modulo NR.
  - No winner if no req_i is set.
- Forwarding:
  - With a winner and FIFO not full: tcdm_req_o=1 and tcdm_add/wen/be/data_o are the winner's fields.
  - Otherwise tcdm_req_o=0 and the data fields carry requester 0's fields (don't care).
- Grant:
  - gnt_o[k] = tcdm_gnt_i & tcdm_req_o & (k==winner).
  - At most one gnt_o bit is set per cycle.
- Handshake (tcdm_req_o & tcdm_gnt_i) on a rising edge:
  - Push the winner ID into the FIFO.
  - Pointer becomes (winner+1) mod NR.
  - With no handshake the pointer holds. A requester left waiting for memory grant keeps priority.
- Requests are combinational pass-through: zero added latency on the request path.
- Response path:
  - Every granted transaction, read or write, returns exactly one tcdm_r_valid_i, in order, no earlier than the cycle after its grant.
  - On tcdm_r_valid_i with the FIFO non-empty: r_valid_o[head]=1 in the same cycle, then pop.
  - r_data_o = tcdm_r_data_i always.
- FIFO full:
  - tcdm_req_o is forced to 0 and no gnt_o is issued, even if a pop happens in the same cycle. There is no combinational path from r_valid to req.
- Simultaneous push and pop with the FIFO not full: occupancy unchanged, both operations performed.
- tcdm_r_valid_i with the FIFO empty:
  - r_valid_o stays all 0 and err_o is set sticky until reset/clear.
- Requester rules:
  - A requester must hold req and its fields stable until granted.
  - The arbiter does not register request fields.
- Reset or clear mid-operation:
  - In-flight IDs are discarded.
  - Any later r_valid for those IDs is treated as the empty-FIFO case (err_o).
- Occupancy counter width: clog2(MAX_OUTSTANDING)+1; counts 0..MAX_OUTSTANDING inclusive.

Decomposition:
- Package fir_arb_pkg holds:
  - the requester-ID typedef (logic [clog2(NR)-1:0]);
  - a function for round-robin first-one-from-pointer;
  - default constants NR_DEFAULT=4 and MAX_OUTSTANDING_DEFAULT=4.
- Sub-module fir_tcdm_id_fifo: synchronous FIFO with push/pop/full/empty/count, async active-high reset plus clear_i.
- The top module holds the rr pointer, winner logic, muxing, response routing and err_o.

Test Plan:
- Fairness: all 4 requesters hold req, tcdm_gnt_i=1, 1-cycle response -> grants in order 0,1,2,3,0 on consecutive cycles; each r_valid_o[k] arrives exactly one cycle after gnt_o[k].
- Pointer priority: pointer=2, req_i=4'b1011 -> requester 3 is granted, then requester 0 next cycle, then 1.
- Grant stall: req_i[1] only, tcdm_gnt_i=0 for 5 cycles, then 1 -> gnt_o[1] only in the 6th cycle; tcdm_add_o equals add_i[1] throughout.
- Full FIFO: MAX_OUTSTANDING=4, 4 grants with r_valid withheld -> outstanding_o=4; tcdm_req_o=0 while req_i is held; after one r_valid, the next cycle grants again.
- Out-of-order issue, in-order return: grants to 2,0,3 with responses delayed by 3 cycles -> r_valid_o pulses 2, then 0, then 3, with r_data_o matching the injected data 0xA5A5_0002, 0xA5A5_0000, 0xA5A5_0003.
- Error/reset: tcdm_r_valid_i pulse while empty -> err_o=1 and stays 1; assert rst_i asynchronously mid-burst -> err_o=0, outstanding_o=0, pointer=0 immediately.
